matlusolve3: RTL and testbench

//  Solves A*x = b for x, given the pivoted LU factorisation of A produced by the upstream matlu3 stage.

---
 rtl/matlusolve3_pkg.sv | 33 +++
 rtl/matlusolve3_if.sv | 25 ++
 rtl/matlusolve3_arith.sv | 115 +++++++++++
 rtl/matlusolve3.sv | 202 ++++++++++++++++++++
 tb/tb_matlusolve3.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matlusolve3_pkg.sv
// matlusolve3 shared types: FSM encodings, fixed-point constants
// and the packed-matrix index helper.
package matlusolve3_pkg;

  localparam int DW = 16;
  localparam int BP = 8;
  localparam int MN = 3;
  localparam logic [DW-1:0] ONE = DW'(1) << BP;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PERM,
    S_FWD_MUL,
    S_FWD_SUB,
    S_BWD_INIT,
    S_BWD_MUL,
    S_BWD_SUB,
    S_BWD_CHK,
    S_BWD_DIV,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    D_LOAD,
    D_RUN,
    D_DONE
  } dstate_e;

  function automatic int elem(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/matlusolve3_if.sv
// matlusolve3 request/result bundle.
// master drives operands and start; slave is the solver.
interface matlusolve3_if #(
  parameter int W = 16,
  parameter int N = 3
);
  logic               start;
  logic [N*N*W-1:0]   lu;
  logic [(N+1)*W-1:0] p;
  logic [N*W-1:0]     b;
  logic               ready;
  logic               complete;
  logic               singular;
  logic [N*W-1:0]     x;

  modport master (
    output start, lu, p, b,
    input  ready, complete, singular, x
  );

  modport slave (
    input  start, lu, p, b,
    output ready, complete, singular, x
  );
endinterface

// File: rtl/matlusolve3_arith.sv
// Fixed-point mul (registered, truncating) and div (restoring,
// runs while rst is low, holds result until rst) shared with matlu3.
module matlusolve3_mul #(
  parameter int W  = 16,
  parameter int BP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] p
);
  logic signed [2*W-1:0] full;
  logic signed [W-1:0]   p_d;
  logic signed [W-1:0]   p_q;

  assign full = a * b;
  assign p_d  = W'(full >>> BP);
  assign p    = p_q;

  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end
endmodule

module matlusolve3_div
  import matlusolve3_pkg::*;
#(
  parameter int W  = 16,
  parameter int BP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] q,
  output logic                complete,
  output logic                singular
);
  localparam int DV = W + BP;
  localparam int CW = $clog2(DV + 1);

  dstate_e       st_q, st_d;
  logic [DV-1:0] quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dsr_q, dsr_d;
  logic          neg_q, neg_d;
  logic          sing_q, sing_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mag_a, mag_b;
  logic [W:0]    shifted;
  logic          ge;

  always_comb begin
    mag_a   = a[W-1] ? W'(-a) : W'(a);
    mag_b   = b[W-1] ? W'(-b) : W'(b);
    shifted = {rem_q, quo_q[DV-1]};
    ge      = shifted >= {1'b0, dsr_q};
    st_d    = st_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    neg_d   = neg_q;
    sing_d  = sing_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      D_LOAD: begin
        if (b == '0) begin
          sing_d = 1'b1;
          st_d   = D_DONE;
        end else begin
          quo_d = {mag_a, {BP{1'b0}}};
          dsr_d = mag_b;
          rem_d = '0;
          cnt_d = '0;
          neg_d = a[W-1] ^ b[W-1];
          st_d  = D_RUN;
        end
      end
      D_RUN: begin
        quo_d = {quo_q[DV-2:0], ge};
        rem_d = ge ? W'(shifted - {1'b0, dsr_q}) : W'(shifted);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DV - 1)) st_d = D_DONE;
      end
      D_DONE: ;
      default: st_d = D_LOAD;
    endcase
  end

  assign q        = W'(neg_q ? (~quo_q + 1'b1) : quo_q);
  assign complete = (st_q == D_DONE);
  assign singular = sing_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= D_LOAD;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
      neg_q  <= 1'b0;
      sing_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
      neg_q  <= neg_d;
      sing_q <= sing_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/matlusolve3.sv
// matlusolve3: solves A*x = b from matlu3's pivoted L\U factors
// (permute b, forward-substitute unit L, back-substitute U).
module matlusolve3
  import matlusolve3_pkg::*;
#(
  parameter int DATA_WIDTH  = DW,
  parameter int BIN_POS     = BP,
  parameter int MATRIX_SIZE = MN
) (
  input  logic          clk,
  input  logic          rst,
  matlusolve3_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = MATRIX_SIZE;
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef logic signed [W-1:0] word_t;

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  word_t         acc_q, acc_d;
  logic          sing_q, sing_d;
  word_t         lu_q [N][N];
  word_t         lu_d [N][N];
  logic [W-1:0]  p_q [N];
  logic [W-1:0]  p_d [N];
  word_t         b_q [N];
  word_t         b_d [N];
  word_t         y_q [N];
  word_t         y_d [N];
  word_t         xw_q [N];
  word_t         xw_d [N];
  word_t         x_q [N];
  word_t         x_d [N];

  word_t mul_a, mul_b, mul_p;
  word_t div_b, div_q;
  logic  div_rst, div_done, div_sing;
  logic  unused_swaps;

  // trailing p entry is matlu3's swap count; not needed here
  assign unused_swaps = ^bus.p[N*W +: W];

  assign mul_a   = lu_q[i_q][j_q];
  assign mul_b   = (state_q == S_FWD_MUL) ? y_q[j_q] : xw_q[j_q];
  assign div_b   = lu_q[i_q][i_q];
  assign div_rst = rst || (state_q != S_BWD_DIV);

  matlusolve3_mul #(.W(W), .BP(BIN_POS)) u_mul (
    .clk (clk),
    .rst (rst),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  matlusolve3_div #(.W(W), .BP(BIN_POS)) u_div (
    .clk      (clk),
    .rst      (div_rst),
    .a        (acc_q),
    .b        (div_b),
    .q        (div_q),
    .complete (div_done),
    .singular (div_sing)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    sing_d  = sing_q;
    lu_d    = lu_q;
    p_d     = p_q;
    b_d     = b_q;
    y_d     = y_q;
    xw_d    = xw_q;
    x_d     = x_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++)
              lu_d[r][c] = bus.lu[elem(r, c, N)*W +: W];
            p_d[r] = bus.p[r*W +: W];
            b_d[r] = bus.b[r*W +: W];
          end
          sing_d  = 1'b0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_PERM;
        end
      end
      S_PERM: begin
        for (int r = 0; r < N; r++) begin
          y_d[r] = '0;
          for (int m = 0; m < N; m++)
            if (p_q[r] == W'(m)) y_d[r] = b_q[m];
        end
        i_d     = IW'(1);
        j_d     = '0;
        state_d = (N > 1) ? S_FWD_MUL : S_BWD_INIT;
      end
      S_FWD_MUL: state_d = S_FWD_SUB;
      S_FWD_SUB: begin
        y_d[i_q] = y_q[i_q] - mul_p;
        if (j_q == i_q - IW'(1)) begin
          if (i_q == LAST) begin
            state_d = S_BWD_INIT;
          end else begin
            i_d     = i_q + IW'(1);
            j_d     = '0;
            state_d = S_FWD_MUL;
          end
        end else begin
          j_d     = j_q + IW'(1);
          state_d = S_FWD_MUL;
        end
      end
      S_BWD_INIT: begin
        acc_d   = y_q[i_q];
        j_d     = i_q + IW'(1);
        state_d = (i_q == LAST) ? S_BWD_CHK : S_BWD_MUL;
      end
      S_BWD_MUL: state_d = S_BWD_SUB;
      S_BWD_SUB: begin
        acc_d   = acc_q - mul_p;
        j_d     = j_q + IW'(1);
        state_d = (j_q == LAST) ? S_BWD_CHK : S_BWD_MUL;
      end
      S_BWD_CHK: begin
        if (div_b == '0) begin
          sing_d = 1'b1;
          for (int r = 0; r < N; r++) x_d[r] = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_BWD_DIV;
        end
      end
      S_BWD_DIV: begin
        if (div_done) begin
          if (div_sing) begin
            sing_d = 1'b1;
            for (int r = 0; r < N; r++) x_d[r] = '0;
            state_d = S_DONE;
          end else begin
            xw_d[i_q] = div_q;
            if (i_q == '0) begin
              x_d     = xw_d;
              state_d = S_DONE;
            end else begin
              i_d     = i_q - IW'(1);
              state_d = S_BWD_INIT;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      sing_q  <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) lu_q[r][c] <= '0;
        p_q[r]  <= '0;
        b_q[r]  <= '0;
        y_q[r]  <= '0;
        xw_q[r] <= '0;
        x_q[r]  <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      sing_q  <= sing_d;
      lu_q    <= lu_d;
      p_q     <= p_d;
      b_q     <= b_d;
      y_q     <= y_d;
      xw_q    <= xw_d;
      x_q     <= x_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.complete = (state_q == S_DONE);
  assign bus.singular = sing_q;

  for (genvar k = 0; k < N; k++) begin : g_x
    assign bus.x[k*W +: W] = x_q[k];
  end
endmodule

// File: tb/tb_matlusolve3.sv
// Self-checking bench for matlusolve3: directed cases plus random
// solves against a plain-arithmetic substitution model.
module tb_matlusolve3;
  import matlusolve3_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matlusolve3_if bif ();

  matlusolve3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] lu_m [3][3];
  logic [15:0] p_m [3];
  logic [15:0] b_m [3];
  logic [47:0] exp_x;
  logic        exp_sing;
  bit          timed_out;

  function automatic int sx(input logic [15:0] v);
    logic signed [15:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int wrap(input longint v);
    return sx(v[15:0]);
  endfunction

  function automatic int mulf(input int a, input int b);
    longint pr;
    pr = longint'(a) * longint'(b);
    return wrap(pr >>> 8);
  endfunction

  function automatic int divf(input int a, input int d);
    longint n;
    n = longint'(a) * 256;
    return wrap(n / longint'(d));
  endfunction

  // Straight textbook permute / forward / back substitution.
  task automatic model();
    int y [3];
    int xv [3];
    int acc;
    exp_sing = 1'b0;
    for (int i = 0; i < 3; i++)
      y[i] = (p_m[i] < 16'd3) ? sx(b_m[int'(p_m[i])]) : 0;
    for (int i = 1; i < 3; i++)
      for (int j = 0; j < i; j++)
        y[i] = wrap(longint'(y[i]) - mulf(sx(lu_m[i][j]), y[j]));
    for (int i = 0; i < 3; i++) xv[i] = 0;
    for (int i = 2; i >= 0; i--) begin
      if (!exp_sing) begin
        acc = y[i];
        for (int j = i + 1; j < 3; j++)
          acc = wrap(longint'(acc) - mulf(sx(lu_m[i][j]), xv[j]));
        if (lu_m[i][i] == 16'h0000) exp_sing = 1'b1;
        else xv[i] = divf(acc, sx(lu_m[i][i]));
      end
    end
    for (int i = 0; i < 3; i++)
      exp_x[i*16 +: 16] = exp_sing ? 16'h0000 : 16'(xv[i]);
  endtask

  task automatic set_identity();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        lu_m[r][c] = (r == c) ? ONE : 16'h0000;
    for (int r = 0; r < 3; r++) p_m[r] = 16'(r);
  endtask

  task automatic load_bus();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++)
        bif.lu[(r*3+c)*16 +: 16] = lu_m[r][c];
      bif.p[r*16 +: 16] = p_m[r];
      bif.b[r*16 +: 16] = b_m[r];
    end
    bif.p[48 +: 16] = 16'($urandom_range(0, 3));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_bus();
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bif.complete && n < 400) begin
      @(negedge clk);
      n++;
    end
    timed_out = !bif.complete;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bif.ready !== 1'b1 || bif.complete !== 1'b0 ||
        bif.singular !== 1'b0 || bif.x !== 48'h0) begin
      errors++;
      $display("FAIL reset: ready=%b complete=%b singular=%b x=%h, want 1 0 0 0",
               bif.ready, bif.complete, bif.singular, bif.x);
    end
  endtask

  task automatic test_identity();
    set_identity();
    b_m[0] = 16'h0100; b_m[1] = 16'h0200; b_m[2] = 16'hFF00;
    pulse_start();
    wait_done();
    checks++;
    if (timed_out || bif.x !== 48'hFF00_0200_0100 || bif.singular !== 1'b0) begin
      errors++;
      $display("FAIL identity: to=%0b x=%h sing=%b, want x=ff0002000100 sing=0",
               timed_out, bif.x, bif.singular);
    end
  endtask

  task automatic test_perm();
    set_identity();
    p_m[0] = 16'd2; p_m[1] = 16'd0; p_m[2] = 16'd1;
    b_m[0] = 16'h0100; b_m[1] = 16'h0200; b_m[2] = 16'h0300;
    pulse_start();
    wait_done();
    checks++;
    if (timed_out || bif.x !== 48'h0200_0100_0300 || bif.singular !== 1'b0) begin
      errors++;
      $display("FAIL perm: to=%0b x=%h sing=%b, want x=020001000300 sing=0",
               timed_out, bif.x, bif.singular);
    end
  endtask

  task automatic set_general();
    lu_m[0][0] = 16'h0400; lu_m[0][1] = 16'h0200; lu_m[0][2] = 16'h0000;
    lu_m[1][0] = 16'h0080; lu_m[1][1] = 16'h0200; lu_m[1][2] = 16'h0100;
    lu_m[2][0] = 16'h0040; lu_m[2][1] = 16'h0080; lu_m[2][2] = 16'h0200;
    for (int r = 0; r < 3; r++) p_m[r] = 16'(r);
    b_m[0] = 16'h0400; b_m[1] = 16'h0400; b_m[2] = 16'h0300;
  endtask

  task automatic test_general();
    set_general();
    pulse_start();
    wait_done();
    checks++;
    if (timed_out || bif.x !== 48'h0080_00C0_00A0 || bif.singular !== 1'b0) begin
      errors++;
      $display("FAIL general: to=%0b x=%h sing=%b, want x=008000c000a0 sing=0",
               timed_out, bif.x, bif.singular);
    end
  endtask

  task automatic test_singular();
    set_general();
    lu_m[1][1] = 16'h0000;
    pulse_start();
    wait_done();
    checks++;
    if (timed_out || bif.x !== 48'h0 || bif.singular !== 1'b1 ||
        bif.ready !== 1'b1) begin
      errors++;
      $display("FAIL singular: to=%0b x=%h sing=%b ready=%b, want x=0 sing=1 ready=1",
               timed_out, bif.x, bif.singular, bif.ready);
    end
  endtask

  task automatic test_rst_mid();
    bit bad;
    set_general();
    pulse_start();
    bad = 1'b0;
    repeat (5) begin
      if (bif.complete !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    if (bif.complete !== 1'b0) bad = 1'b1;
    rst = 1'b0;
    checks++;
    if (bad || bif.ready !== 1'b1 || bif.x !== 48'h0 || bif.singular !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: early_complete=%0b ready=%b x=%h sing=%b, want 0 1 0 0",
               bad, bif.ready, bif.x, bif.singular);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bif.complete !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle: complete=%b, want 0", bif.complete);
      end
    end
    test_identity();
  endtask

  task automatic test_back_to_back();
    bit bad;
    set_general();
    model();
    pulse_start();
    repeat (3) @(negedge clk);
    b_m[0] = 16'h1234; b_m[1] = 16'hF00D; b_m[2] = 16'h0777;
    load_bus();
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    wait_done();
    checks++;
    if (timed_out || bif.x !== exp_x || bif.singular !== exp_sing) begin
      errors++;
      $display("FAIL busy_start: to=%0b x=%h sing=%b, want x=%h sing=%b",
               timed_out, bif.x, bif.singular, exp_x, exp_sing);
    end
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bif.complete !== 1'b1 || bif.x !== exp_x) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL hold: complete=%b x=%h, want 1 and %h", bif.complete, bif.x, exp_x);
    end
    set_identity();
    b_m[0] = 16'h0300; b_m[1] = 16'h8000; b_m[2] = 16'h7FFF;
    model();
    load_bus();
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    checks++;
    if (bif.complete !== 1'b0 || bif.ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_drop: complete=%b ready=%b, want 0 0",
               bif.complete, bif.ready);
    end
    wait_done();
    checks++;
    if (timed_out || bif.x !== exp_x || bif.singular !== exp_sing) begin
      errors++;
      $display("FAIL restart_result: to=%0b x=%h sing=%b, want x=%h sing=%b",
               timed_out, bif.x, bif.singular, exp_x, exp_sing);
    end
  endtask

  task automatic test_random();
    int r;
    logic [15:0] t;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          if (i == j) begin
            t = 16'($urandom_range(64, 1024));
            lu_m[i][j] = $urandom_range(0, 1) ? -t : t;
          end else if (j < i) begin
            lu_m[i][j] = 16'($urandom_range(0, 512)) - 16'd256;
          end else begin
            lu_m[i][j] = 16'($urandom_range(0, 1024)) - 16'd512;
          end
        end
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 2);
        lu_m[r][r] = 16'h0000;
      end
      for (int i = 0; i < 3; i++) p_m[i] = 16'(i);
      for (int k = 2; k > 0; k--) begin
        r = $urandom_range(0, k);
        t = p_m[k]; p_m[k] = p_m[r]; p_m[r] = t;
      end
      if ($urandom_range(0, 5) == 0)
        p_m[$urandom_range(0, 2)] = 16'($urandom_range(3, 300));
      for (int i = 0; i < 3; i++) b_m[i] = 16'($urandom_range(0, 65535));
      model();
      pulse_start();
      wait_done();
      checks++;
      if (timed_out || bif.x !== exp_x || bif.singular !== exp_sing) begin
        errors++;
        $display("FAIL random[%0d]: to=%0b x=%h sing=%b, want x=%h sing=%b",
                 it, timed_out, bif.x, bif.singular, exp_x, exp_sing);
      end
    end
  endtask

  initial begin
    bif.start = 1'b0;
    bif.lu    = '0;
    bif.p     = '0;
    bif.b     = '0;
    test_reset();
    test_identity();
    test_perm();
    test_general();
    test_singular();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
